// File: rtl/axi4_lite_slave_regs.sv
// axi4_lite_slave_regs
// AXI4-Lite slave that holds NUM_REGS 32-bit control registers. It accepts
// single-beat writes with byte strobes and single-beat reads, and answers
// OKAY, or SLVERR for addresses outside the decoded span.
//
// Ports:
//   aclk, areset            clock and synchronous active-high reset
//   s_axi_aw* / s_axi_w*    write address / write data channels
//   s_axi_b*                write response channel
//   s_axi_ar* / s_axi_r*    read address / read data channels
//   regs_out                flat register image, reg i at [32i+31:32i]
//   reg_wr_pulse            one-cycle strobe per register after a write
module axi4_lite_slave_regs #(
  parameter int NUM_REGS   = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic [ADDR_WIDTH-1:0]    s_axi_awaddr,
  input  logic [2:0]               s_axi_awprot,
  input  logic                     s_axi_awvalid,
  output logic                     s_axi_awready,
  input  logic [31:0]              s_axi_wdata,
  input  logic [3:0]               s_axi_wstrb,
  input  logic                     s_axi_wvalid,
  output logic                     s_axi_wready,
  output logic [1:0]               s_axi_bresp,
  output logic                     s_axi_bvalid,
  input  logic                     s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]    s_axi_araddr,
  input  logic [2:0]               s_axi_arprot,
  input  logic                     s_axi_arvalid,
  output logic                     s_axi_arready,
  output logic [31:0]              s_axi_rdata,
  output logic [1:0]               s_axi_rresp,
  output logic                     s_axi_rvalid,
  input  logic                     s_axi_rready,
  output logic [NUM_REGS*32-1:0]   regs_out,
  output logic [NUM_REGS-1:0]      reg_wr_pulse
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state, w_state_next;
  r_state_t r_state, r_state_next;

  logic [31:0] regs [NUM_REGS];

  logic                  aw_held, w_held;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [31:0]           w_data_q;
  logic [3:0]            w_strb_q;

  logic                  aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic                  aw_have, w_have, commit;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]           wr_data;
  logic [3:0]            wr_strb;
  logic                  wr_in_range, rd_in_range;
  logic [IDX_W-1:0]      wr_idx, rd_idx;

  logic                  aw_held_next, w_held_next;
  logic                  awready_next, wready_next;
  logic [NUM_REGS-1:0]   pulse_next;

  // Byte offset within a word and the protection bits carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{wr_addr[1:0], s_axi_araddr[1:0], s_axi_awprot, s_axi_arprot};

  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid  && s_axi_wready;
  assign ar_hs = s_axi_arvalid && s_axi_arready;
  assign b_hs  = s_axi_bvalid  && s_axi_bready;
  assign r_hs  = s_axi_rvalid  && s_axi_rready;

  // A beat counts as available either from its holding register or from a
  // handshake completing this cycle, so the commit can happen on the same
  // edge as the later of the two handshakes.
  assign aw_have = aw_held || aw_hs;
  assign w_have  = w_held  || w_hs;
  assign commit  = (w_state == W_IDLE) && aw_have && w_have;

  assign wr_addr = aw_held ? aw_addr_q : s_axi_awaddr;
  assign wr_data = w_held  ? w_data_q  : s_axi_wdata;
  assign wr_strb = w_held  ? w_strb_q  : s_axi_wstrb;

  // Anything at or above NUM_REGS*4 has a nonzero bit above the index field.
  assign wr_in_range = (wr_addr[ADDR_WIDTH-1:IDX_W+2] == '0);
  assign rd_in_range = (s_axi_araddr[ADDR_WIDTH-1:IDX_W+2] == '0);
  assign wr_idx      = wr_addr[IDX_W+1:2];
  assign rd_idx      = s_axi_araddr[IDX_W+1:2];

  // Ready flags are computed from the current state and registered, which
  // leaves one idle cycle with both readies low after each B handshake.
  always_comb begin
    w_state_next = w_state;
    aw_held_next = 1'b0;
    w_held_next  = 1'b0;
    awready_next = 1'b0;
    wready_next  = 1'b0;
    pulse_next   = '0;
    case (w_state)
      W_IDLE: begin
        if (commit) begin
          w_state_next = W_RESP;
          if (wr_in_range) pulse_next[wr_idx] = 1'b1;
        end else begin
          aw_held_next = aw_have;
          w_held_next  = w_have;
          awready_next = !aw_have;
          wready_next  = !w_have;
        end
      end
      W_RESP: begin
        if (b_hs) w_state_next = W_IDLE;
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      w_state       <= W_IDLE;
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      aw_addr_q     <= '0;
      w_data_q      <= '0;
      w_strb_q      <= '0;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
      reg_wr_pulse  <= '0;
    end else begin
      w_state       <= w_state_next;
      aw_held       <= aw_held_next;
      w_held        <= w_held_next;
      s_axi_awready <= awready_next;
      s_axi_wready  <= wready_next;
      reg_wr_pulse  <= pulse_next;
      if (aw_hs) aw_addr_q <= s_axi_awaddr;
      if (w_hs) begin
        w_data_q <= s_axi_wdata;
        w_strb_q <= s_axi_wstrb;
      end
      if (commit) begin
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
      end else if (b_hs) begin
        s_axi_bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (commit && wr_in_range) begin
      for (int k = 0; k < 4; k++) begin
        if (wr_strb[k]) regs[wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
      end
    end
  end

  always_comb begin
    r_state_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_state_next = R_DATA;
      R_DATA:  if (r_hs)  r_state_next = R_IDLE;
      default: r_state_next = R_IDLE;
    endcase
  end

  // Read data is sampled before any same-edge write lands, so a colliding
  // read returns the pre-write value.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state       <= R_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= RESP_OKAY;
    end else begin
      r_state       <= r_state_next;
      s_axi_arready <= (r_state_next == R_IDLE);
      s_axi_rvalid  <= (r_state_next == R_DATA);
      if (ar_hs) begin
        s_axi_rdata <= rd_in_range ? regs[rd_idx] : 32'h0;
        s_axi_rresp <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
    assign regs_out[32*g +: 32] = regs[g];
  end

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// tb_axi4_lite_slave_regs
// Directed bench for axi4_lite_slave_regs. A transaction-level model tracks
// register contents and outstanding responses; a compare process checks the
// DUT against it every cycle, and directed checks pin exact timing.
module tb_axi4_lite_slave_regs;

  localparam int NUM_REGS = 4;

  logic                   aclk;
  logic                   areset;
  logic [31:0]            s_axi_awaddr;
  logic [2:0]             s_axi_awprot;
  logic                   s_axi_awvalid;
  logic                   s_axi_awready;
  logic [31:0]            s_axi_wdata;
  logic [3:0]             s_axi_wstrb;
  logic                   s_axi_wvalid;
  logic                   s_axi_wready;
  logic [1:0]             s_axi_bresp;
  logic                   s_axi_bvalid;
  logic                   s_axi_bready;
  logic [31:0]            s_axi_araddr;
  logic [2:0]             s_axi_arprot;
  logic                   s_axi_arvalid;
  logic                   s_axi_arready;
  logic [31:0]            s_axi_rdata;
  logic [1:0]             s_axi_rresp;
  logic                   s_axi_rvalid;
  logic                   s_axi_rready;
  logic [NUM_REGS*32-1:0] regs_out;
  logic [NUM_REGS-1:0]    reg_wr_pulse;

  axi4_lite_slave_regs #(.NUM_REGS(NUM_REGS), .ADDR_WIDTH(32)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awprot  (s_axi_awprot),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arprot  (s_axi_arprot),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .regs_out      (regs_out),
    .reg_wr_pulse  (reg_wr_pulse)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct packed {
    logic        is_write;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
  } vec_t;

  // Model state: register image, outstanding responses, pending beats.
  logic [31:0]         model_regs [NUM_REGS];
  logic [1:0]          bq [$];
  logic [33:0]         rq [$];
  logic [NUM_REGS-1:0] exp_pulse = '0;
  bit                  model_live = 1'b0;
  int                  pulse_cnt [NUM_REGS];

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_miss++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  function automatic logic [127:0] modelFlat();
    logic [127:0] f;
    f = '0;
    for (int i = 0; i < NUM_REGS; i++) f[32*i +: 32] = model_regs[i];
    return f;
  endfunction

  function automatic logic [33:0] modelRead(input logic [31:0] addr);
    if (addr < 32'(NUM_REGS*4)) return {2'b00, model_regs[int'(addr / 4)]};
    return {2'b10, 32'h0};
  endfunction

  // Transaction-level model: observes handshakes at the clock edge.
  initial begin : model
    logic [31:0] m_aw, m_w;
    logic [3:0]  m_strb;
    bit          m_aw_ok, m_w_ok;
    int          idx;
    m_aw_ok = 0;
    m_w_ok  = 0;
    forever begin
      @(posedge aclk);
      if (areset) begin
        for (int i = 0; i < NUM_REGS; i++) model_regs[i] = '0;
        bq.delete();
        rq.delete();
        m_aw_ok    = 0;
        m_w_ok     = 0;
        exp_pulse  = '0;
        model_live = 1'b1;
      end else begin
        exp_pulse = '0;
        if (s_axi_bvalid && s_axi_bready && bq.size() != 0) void'(bq.pop_front());
        if (s_axi_rvalid && s_axi_rready && rq.size() != 0) void'(rq.pop_front());
        if (s_axi_arvalid && s_axi_arready) rq.push_back(modelRead(s_axi_araddr));
        if (s_axi_awvalid && s_axi_awready) begin
          m_aw    = s_axi_awaddr;
          m_aw_ok = 1;
        end
        if (s_axi_wvalid && s_axi_wready) begin
          m_w    = s_axi_wdata;
          m_strb = s_axi_wstrb;
          m_w_ok = 1;
        end
        if (m_aw_ok && m_w_ok) begin
          if (m_aw < 32'(NUM_REGS*4)) begin
            idx = int'(m_aw / 4);
            for (int k = 0; k < 4; k++)
              if (m_strb[k]) model_regs[idx][8*k +: 8] = m_w[8*k +: 8];
            exp_pulse[idx] = 1'b1;
            bq.push_back(2'b00);
          end else begin
            bq.push_back(2'b10);
          end
          m_aw_ok = 0;
          m_w_ok  = 0;
        end
      end
    end
  end

  // Compare process: a response is visible exactly while it is outstanding.
  initial begin : compare
    forever begin
      @(negedge aclk);
      if (model_live) begin
        checkOutput("regs_out", regs_out, modelFlat());
        checkOutput("reg_wr_pulse", reg_wr_pulse, exp_pulse);
        checkOutput("bvalid", s_axi_bvalid, bq.size() != 0);
        if (s_axi_bvalid && bq.size() != 0) checkOutput("bresp", s_axi_bresp, bq[0]);
        checkOutput("rvalid", s_axi_rvalid, rq.size() != 0);
        if (s_axi_rvalid && rq.size() != 0)
          checkOutput("rresp_rdata", {s_axi_rresp, s_axi_rdata}, rq[0]);
      end
    end
  end

  initial begin : pulse_counter
    forever begin
      @(negedge aclk);
      if (!areset)
        for (int i = 0; i < NUM_REGS; i++) if (reg_wr_pulse[i]) pulse_cnt[i]++;
    end
  end

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drivers are entered and left on a falling edge.
  task automatic doWrite(input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, output logic [1:0] resp);
    int   cyc;
    logic aw_hs, w_hs;
    s_axi_awaddr  = addr;
    s_axi_awvalid = 1'b1;
    s_axi_wdata   = data;
    s_axi_wstrb   = strb;
    s_axi_wvalid  = 1'b1;
    s_axi_bready  = 1'b1;
    cyc = 0;
    while ((s_axi_awvalid || s_axi_wvalid) && cyc < 20) begin
      aw_hs = s_axi_awvalid && s_axi_awready;
      w_hs  = s_axi_wvalid && s_axi_wready;
      @(negedge aclk);
      if (aw_hs) s_axi_awvalid = 1'b0;
      if (w_hs)  s_axi_wvalid  = 1'b0;
      cyc++;
    end
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    while (!s_axi_bvalid && cyc < 40) begin
      @(negedge aclk);
      cyc++;
    end
    checkOutput($sformatf("wr_done@%h", addr), s_axi_bvalid, 1'b1);
    resp = s_axi_bresp;
    @(negedge aclk);
  endtask

  task automatic doRead(input logic [31:0] addr, output logic [31:0] data,
                        output logic [1:0] resp);
    int   cyc;
    logic hs;
    s_axi_araddr  = addr;
    s_axi_arvalid = 1'b1;
    s_axi_rready  = 1'b1;
    cyc = 0;
    while (s_axi_arvalid && cyc < 20) begin
      hs = s_axi_arvalid && s_axi_arready;
      @(negedge aclk);
      if (hs) s_axi_arvalid = 1'b0;
      cyc++;
    end
    s_axi_arvalid = 1'b0;
    while (!s_axi_rvalid && cyc < 40) begin
      @(negedge aclk);
      cyc++;
    end
    checkOutput($sformatf("rd_done@%h", addr), s_axi_rvalid, 1'b1);
    data = s_axi_rdata;
    resp = s_axi_rresp;
    @(negedge aclk);
  endtask

  task automatic applyStimulus(input vec_t v);
    logic [31:0] rd;
    logic [1:0]  resp;
    if (v.is_write) begin
      doWrite(v.addr, v.data, v.strb, resp);
      checkOutput($sformatf("bresp@%h", v.addr), resp, v.resp);
    end else begin
      doRead(v.addr, rd, resp);
      checkOutput($sformatf("rdata@%h", v.addr), rd, v.data);
      checkOutput($sformatf("rresp@%h", v.addr), resp, v.resp);
    end
  endtask

  function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s, input logic [1:0] r);
    vec_t v;
    v.is_write = w;
    v.addr     = a;
    v.data     = d;
    v.strb     = s;
    v.resp     = r;
    return v;
  endfunction

  initial begin : main
    vec_t phase_a [$];
    vec_t phase_b [$];

    areset        = 1'b1;
    s_axi_awaddr  = '0;
    s_axi_awprot  = '0;
    s_axi_awvalid = 1'b0;
    s_axi_wdata   = '0;
    s_axi_wstrb   = '0;
    s_axi_wvalid  = 1'b0;
    s_axi_bready  = 1'b1;
    s_axi_araddr  = '0;
    s_axi_arprot  = '0;
    s_axi_arvalid = 1'b0;
    s_axi_rready  = 1'b1;

    // Reset state, then readiness in the first cycle after release.
    @(negedge aclk);
    checkOutput("rst_awready", s_axi_awready, 1'b0);
    checkOutput("rst_wready", s_axi_wready, 1'b0);
    checkOutput("rst_arready", s_axi_arready, 1'b0);
    checkOutput("rst_regs_out", regs_out, 128'h0);
    areset = 1'b0;
    @(negedge aclk);
    checkOutput("rel_awready", s_axi_awready, 1'b1);
    checkOutput("rel_wready", s_axi_wready, 1'b1);
    checkOutput("rel_arready", s_axi_arready, 1'b1);

    // Basic write / readback.
    phase_a.push_back(mk(1, 32'h0, 32'hDEADBEEF, 4'hF, 2'b00));
    phase_a.push_back(mk(1, 32'h4, 32'h00000001, 4'hF, 2'b00));
    phase_a.push_back(mk(1, 32'h8, 32'h00000002, 4'hF, 2'b00));
    phase_a.push_back(mk(0, 32'h0, 32'hDEADBEEF, 4'h0, 2'b00));
    phase_a.push_back(mk(0, 32'h4, 32'h00000001, 4'h0, 2'b00));
    phase_a.push_back(mk(0, 32'h8, 32'h00000002, 4'h0, 2'b00));
    foreach (phase_a[i]) applyStimulus(phase_a[i]);
    checkOutput("regs_after_basic", regs_out, {32'h0, 32'h2, 32'h1, 32'hDEADBEEF});
    checkOutput("pulse_cnt0", pulse_cnt[0], 1);
    checkOutput("pulse_cnt1", pulse_cnt[1], 1);
    checkOutput("pulse_cnt2", pulse_cnt[2], 1);
    checkOutput("pulse_cnt3", pulse_cnt[3], 0);

    // Strobes, out-of-range, empty strobe, ignored low bits, high-bit decode.
    phase_b.push_back(mk(1, 32'h0,        32'h11223344, 4'b0101, 2'b00));
    phase_b.push_back(mk(0, 32'h0,        32'hDE22BE44, 4'h0,    2'b00));
    phase_b.push_back(mk(1, 32'h10,       32'hCAFEF00D, 4'hF,    2'b10));
    phase_b.push_back(mk(0, 32'h10,       32'h00000000, 4'h0,    2'b10));
    phase_b.push_back(mk(1, 32'h4,        32'hFFFFFFFF, 4'h0,    2'b00));
    phase_b.push_back(mk(0, 32'h4,        32'h00000001, 4'h0,    2'b00));
    phase_b.push_back(mk(0, 32'h3,        32'hDE22BE44, 4'h0,    2'b00));
    phase_b.push_back(mk(0, 32'hC,        32'h00000000, 4'h0,    2'b00));
    phase_b.push_back(mk(0, 32'h80000004, 32'h00000000, 4'h0,    2'b10));
    foreach (phase_b[i]) applyStimulus(phase_b[i]);
    checkOutput("regs_after_strobe", regs_out, {32'h0, 32'h2, 32'h1, 32'hDE22BE44});
    checkOutput("pulse_cnt1_empty_strb", pulse_cnt[1], 2);

    // W leads AW by 3 cycles; B stalled for 5 cycles.
    repeat (2) @(negedge aclk);
    s_axi_bready = 1'b0;
    s_axi_wdata  = 32'h5;
    s_axi_wstrb  = 4'hF;
    s_axi_wvalid = 1'b1;
    checkOutput("stall_wready_pre", s_axi_wready, 1'b1);
    @(negedge aclk);
    s_axi_wvalid = 1'b0;
    checkOutput("stall_wready_drop", s_axi_wready, 1'b0);
    repeat (2) @(negedge aclk);
    checkOutput("stall_bvalid_pre", s_axi_bvalid, 1'b0);
    checkOutput("stall_awready_pre", s_axi_awready, 1'b1);
    s_axi_awaddr  = 32'hC;
    s_axi_awvalid = 1'b1;
    @(negedge aclk);
    s_axi_awvalid = 1'b0;
    checkOutput("stall_pulse", reg_wr_pulse, 4'b1000);
    checkOutput("stall_reg3", regs_out[127:96], 32'h5);
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_bvalid", s_axi_bvalid, 1'b1);
      checkOutput("stall_bresp", s_axi_bresp, 2'b00);
      checkOutput("stall_awready", s_axi_awready, 1'b0);
      checkOutput("stall_wready", s_axi_wready, 1'b0);
      @(negedge aclk);
    end
    s_axi_bready = 1'b1;
    @(negedge aclk);
    checkOutput("stall_bvalid_fall", s_axi_bvalid, 1'b0);
    checkOutput("stall_gap_awready", s_axi_awready, 1'b0);
    checkOutput("stall_gap_wready", s_axi_wready, 1'b0);
    @(negedge aclk);
    checkOutput("stall_awready_back", s_axi_awready, 1'b1);
    checkOutput("stall_wready_back", s_axi_wready, 1'b1);

    // Read and write commit on the same edge to reg1.
    s_axi_awaddr  = 32'h4;
    s_axi_awvalid = 1'b1;
    s_axi_wdata   = 32'h77;
    s_axi_wstrb   = 4'hF;
    s_axi_wvalid  = 1'b1;
    s_axi_araddr  = 32'h4;
    s_axi_arvalid = 1'b1;
    checkOutput("coll_arready", s_axi_arready, 1'b1);
    @(negedge aclk);
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    s_axi_arvalid = 1'b0;
    checkOutput("coll_rdata", s_axi_rdata, 32'h1);
    checkOutput("coll_bvalid", s_axi_bvalid, 1'b1);
    @(negedge aclk);
    applyStimulus(mk(0, 32'h4, 32'h00000077, 4'h0, 2'b00));

    // Reset with both responses pending.
    repeat (2) @(negedge aclk);
    s_axi_bready  = 1'b0;
    s_axi_rready  = 1'b0;
    s_axi_awaddr  = 32'h8;
    s_axi_wdata   = 32'hA5A5A5A5;
    s_axi_wstrb   = 4'hF;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid  = 1'b1;
    s_axi_araddr  = 32'h0;
    s_axi_arvalid = 1'b1;
    @(negedge aclk);
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    s_axi_arvalid = 1'b0;
    checkOutput("prerst_bvalid", s_axi_bvalid, 1'b1);
    checkOutput("prerst_rvalid", s_axi_rvalid, 1'b1);
    checkOutput("prerst_reg2", regs_out[95:64], 32'hA5A5A5A5);
    areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    checkOutput("midrst_bvalid", s_axi_bvalid, 1'b0);
    checkOutput("midrst_rvalid", s_axi_rvalid, 1'b0);
    checkOutput("midrst_regs_out", regs_out, 128'h0);
    checkOutput("midrst_awready", s_axi_awready, 1'b0);
    checkOutput("midrst_arready", s_axi_arready, 1'b0);
    @(negedge aclk);
    checkOutput("postrst_awready", s_axi_awready, 1'b1);
    checkOutput("postrst_wready", s_axi_wready, 1'b1);
    checkOutput("postrst_arready", s_axi_arready, 1'b1);
    s_axi_bready = 1'b1;
    s_axi_rready = 1'b1;
    applyStimulus(mk(0, 32'h0, 32'h00000000, 4'h0, 2'b00));

    repeat (2) @(negedge aclk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/axi4_lite_slave_regs.md
# axi4_lite_slave_regs

AXI4-Lite slave register file that terminates the AXI4-Lite master port of the block design and holds NUM_REGS 32-bit control registers. It accepts single-beat writes, with byte strobes, and single-beat reads. It returns OKAY or SLVERR responses and exposes every register, plus a per-register write pulse, to downstream fabric logic. It is the target for the 0x0/0x4/0x8 register write/readback traffic the master agent generates.

## Interface
Parameters:
- NUM_REGS, 4, number of 32-bit registers (power of two, 2..64); decoded byte span NUM_REGS*4
- ADDR_WIDTH, 32, width of awaddr/araddr

Ports:
- aclk  in  1  clock, all logic on rising edge
- areset  in  1  synchronous, active-high reset
- s_axi_awaddr  in  ADDR_WIDTH  write address
- s_axi_awprot  in  3  ignored
- s_axi_awvalid / s_axi_awready  in / out  1  AW handshake
- s_axi_wdata  in  32  write data
- s_axi_wstrb  in  4  byte enables
- s_axi_wvalid / s_axi_wready  in / out  1  W handshake
- s_axi_bresp  out  2  write response (00 OKAY, 10 SLVERR)
- s_axi_bvalid / s_axi_bready  out / in  1  B handshake
- s_axi_araddr  in  ADDR_WIDTH  read address
- s_axi_arprot  in  3  ignored
- s_axi_arvalid / s_axi_arready  in / out  1  AR handshake
- s_axi_rdata  out  32  read data
- s_axi_rresp  out  2  read response
- s_axi_rvalid / s_axi_rready  out / in  1  R handshake
- regs_out  out  NUM_REGS*32  register contents; reg i at bits [32i+31:32i]
- reg_wr_pulse  out  NUM_REGS  one-cycle pulse on the cycle after reg i is written

## Operation
- Address decode:
  - Index = addr[log2(NUM_REGS)+1:2].
  - addr[1:0] is ignored.
  - Any address >= NUM_REGS*4 is out of range.
- Write channel, FSM W_IDLE -> W_RESP -> W_IDLE:
  - In W_IDLE, awready and wready are asserted independently. Each drops once its beat is captured in its holding register.
  - AW and W may arrive in either order or in the same cycle.
  - When both beats are held, the register is written on that edge. Only bytes with wstrb[k]=1 are updated.
  - The FSM then enters W_RESP with bvalid=1 and bresp=OKAY, or bresp=SLVERR if the address is out of range.
  - An out-of-range write leaves all registers unchanged and produces no pulse.
- W_RESP:
  - bvalid and bresp stay stable until bready.
  - awready and wready stay low.
  - On the bready handshake the FSM returns to W_IDLE, and awready/wready rise on the next cycle.
- A wstrb=0000 write is a legal OKAY write. It changes no data but still pulses reg_wr_pulse.
- Read channel, FSM R_IDLE -> R_DATA -> R_IDLE:
  - arready=1 in R_IDLE.
  - On the AR handshake, rdata is captured from the current register value, or 0 if out of range. rresp is OKAY or SLVERR.
  - The FSM then enters R_DATA with rvalid=1. rdata and rresp stay stable until the rready handshake, then the FSM returns to R_IDLE.
- Read and write channels are fully independent and may be active concurrently.
- Simultaneous read handshake and write commit to the same register: the read returns the pre-write value.
- regs_out is driven directly from the register flops.

## Timing
- Reset (areset=1 at a clock edge):
  - All registers, regs_out, reg_wr_pulse, bvalid, rvalid, bresp, rresp and rdata go to 0.
  - awready, wready and arready are 0 while areset=1.
  - In the first cycle after release, awready, wready and arready are 1.
- Reset mid-transaction discards all held AW/W beats and any pending B/R response. Completed register writes are also cleared to 0.
- Write latency: bvalid rises 1 cycle after the later of the AW and W handshakes. regs_out updates at that same edge, and reg_wr_pulse is high for exactly that one cycle.
- Write throughput: with bready tied high, one write completes every 3 cycles (handshake, response, ready re-rise).
- Read latency: rvalid rises 1 cycle after the AR handshake.
- Read throughput: with rready tied high, one read every 2 cycles.
- All outputs are registered, with no combinational path from input to output.

## Test plan
- Write 0xDEADBEEF @0x0, 0x00000001 @0x4, 0x00000002 @0x8 (wstrb=1111), then read back 0x0/0x4/0x8 -> bresp=00 for each write; rdata DEADBEEF, 00000001, 00000002 with rresp=00; regs_out matches; reg_wr_pulse bits 0,1,2 each pulse once.
- Reg0=0xDEADBEEF, then write 0x11223344 @0x0 with wstrb=0101 -> reg0 reads 0xDE22BE44.
- Write 0xCAFEF00D @0x10, then read 0x10 (NUM_REGS=4) -> bresp=10 with no register changed and no pulse; rresp=10 with rdata=0.
- Present W 3 cycles before AW for a write of 0x5 @0xC, hold bready=0 for 5 cycles -> wready drops after W handshake; bvalid rises 1 cycle after AW handshake and stays high with bresp=00 stable for all 5 stall cycles; awready/wready stay 0 until 1 cycle after bready.
- Read @0x4 in the same cycle the write commit of 0x77 @0x4 occurs (reg1=0x1) -> rdata=0x00000001; a following read @0x4 returns 0x00000077.
- Assert areset for 1 cycle while bvalid=1 and rvalid=1 after writes -> bvalid=rvalid=0 and regs_out=0 next cycle; readies return to 1 after release; read @0x0 returns 0.
